// File: rtl/soc_system_adc_capture_pkg.sv
// Shared constants for the ADC capture block: register map and edge-type encodings.
// Build option ADC_CAPTURE_BIT_CLEAR_EN (see top) changes edgecapture clear semantics.
package soc_system_adc_capture_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_RSVD    = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_adc_capture_if.sv
// Avalon-MM slave bus bundle for the ADC capture block (word addressed, read latency 1).
interface soc_system_adc_capture_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/soc_system_adc_capture_sync.sv
// Multi-flop synchronizer for the asynchronous in_port bits plus a per-bit edge detector.
module soc_system_adc_capture_sync
   import soc_system_adc_capture_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] edges
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // NOTE: the synchronizer chain is reset too, so a constant-0 input never
   // reports an edge after release; a constant-1 input reports exactly one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples the previous
         // stage's old value, giving a true shift register.
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALLING: edges = ~sync & prev_q;
         EDGE_ANY:     edges = sync ^ prev_q;
         default:      edges = sync & ~prev_q;
      endcase
   end

endmodule

// File: rtl/soc_system_adc_capture.sv
// ADC status capture peripheral: data / irqmask / edgecapture registers and a level irq.
// Define ADC_CAPTURE_BIT_CLEAR_EN for write-1-to-clear edgecapture; default clears all bits.
module soc_system_adc_capture
   import soc_system_adc_capture_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   soc_system_adc_capture_if.slave   bus,
   input  logic [WIDTH-1:0]          in_port,
   output logic                      irq
);

   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] edges;

   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [WIDTH-1:0] clear_mask;
   logic             wr_en;
   logic             rd_en;

   soc_system_adc_capture_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .sync    (sync),
      .edges   (edges)
   );

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign rd_en = bus.chipselect &  bus.write_n;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case/if tree can leave it unassigned and infer a latch.
      irqmask_d  = irqmask_q;
      clear_mask = '0;
      readdata_d = readdata_q;

      if (wr_en && bus.address == ADDR_IRQMASK) begin
         irqmask_d = bus.writedata[WIDTH-1:0];
      end

      if (wr_en && bus.address == ADDR_EDGECAP) begin
`ifdef ADC_CAPTURE_BIT_CLEAR_EN
         clear_mask = bus.writedata[WIDTH-1:0];
`else
         clear_mask = '1;
`endif
      end

      // A new edge wins over a clear landing in the same cycle.
      edgecap_d = (edgecap_q & ~clear_mask) | edges;

      if (rd_en) begin
         readdata_d = '0;
         case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d            = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_adc_capture.sv
// Self-checking bench for soc_system_adc_capture: vector table, corner sequences, random run.
module tb_soc_system_adc_capture;

   localparam int WIDTH       = 32;
   localparam int EDGE_TYPE   = 0;
   localparam int SYNC_STAGES = 2;

   logic              clk;
   logic              reset_n;
   logic [WIDTH-1:0]  in_port;
   logic              irq;

   soc_system_adc_capture_if bus ();

   soc_system_adc_capture #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: in_port samples flow through a delay line of SYNC_STAGES+1
   // entries; the synchronized value is the one SYNC_STAGES samples old.
   logic [31:0] hist[$];
   logic [31:0] m_edgecap;
   logic [31:0] m_mask;

   always @(posedge clk or negedge reset_n) begin
      logic [31:0] s_v, p_v, flag;
      if (!reset_n) begin
         m_edgecap = '0;
         m_mask    = '0;
         hist      = {};
         for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back('0);
      end else begin
         s_v = hist[SYNC_STAGES-1];
         p_v = hist[SYNC_STAGES];
         if (EDGE_TYPE == 1)      flag = ~s_v & p_v;
         else if (EDGE_TYPE == 2) flag = s_v ^ p_v;
         else                     flag = s_v & ~p_v;
         if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 2'd1) m_mask = bus.writedata;
            if (bus.address == 2'd3) begin
`ifdef ADC_CAPTURE_BIT_CLEAR_EN
               m_edgecap = m_edgecap & ~bus.writedata;
`else
               m_edgecap = '0;
`endif
            end
         end
         m_edgecap = m_edgecap | flag;
         hist.push_front(in_port);
         void'(hist.pop_back());
      end
   end

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return hist[SYNC_STAGES-1];
         2'd1:    return m_mask;
         2'd3:    return m_edgecap;
         default: return '0;
      endcase
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] exp_m);
      @(negedge clk);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      exp_m          = model_read(a);
      @(negedge clk);
      bus.chipselect = 1'b0;
      d              = bus.readdata;
   endtask

   typedef struct {
      logic [31:0] in_val;
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] rd, rd_m;
      logic        seen;

      reset_n        = 1'b0;
      in_port        = '0;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;

      vecs[0] = '{32'h0000_00A5, 1'b0, 2'd0, 32'h0,         32'h0000_00A5, 1'b0};
      vecs[1] = '{32'h0000_00A5, 1'b0, 2'd3, 32'h0,         32'h0000_00A5, 1'b0};
      vecs[2] = '{32'h0000_00A5, 1'b1, 2'd1, 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0};
      vecs[3] = '{32'h0000_00A5, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b0};
      vecs[4] = '{32'h0000_005A, 1'b0, 2'd0, 32'h0,         32'h0000_005A, 1'b0};
      vecs[5] = '{32'h0000_005A, 1'b0, 2'd3, 32'h0,         32'h0000_00FF, 1'b0};
      vecs[6] = '{32'h0000_FF5A, 1'b0, 2'd3, 32'h0,         32'h0000_FFFF, 1'b1};
      vecs[7] = '{32'h0000_FF5A, 1'b1, 2'd1, 32'h0,         32'h0,         1'b0};
      vecs[8] = '{32'h0000_0000, 1'b0, 2'd3, 32'h0,         32'h0000_FFFF, 1'b0};

      wait_cycles(3);
      check("reset_readdata", bus.readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;

      bus_read(2'd0, rd, rd_m);
      check("post_reset_data", rd, 32'h0);
      check("post_reset_irq", {31'b0, irq}, 32'h0);

      for (int i = 0; i < 9; i++) begin
         in_port = vecs[i].in_val;
         wait_cycles(4);
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
         bus_read(vecs[i].addr, rd, rd_m);
         check($sformatf("vec%0d_read", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      end

      // Rising edge on bit0 with mask bit0 set must raise irq within SYNC_STAGES+2 cycles.
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_write(2'd1, 32'h1);
      check("mask1_irq_idle", {31'b0, irq}, 32'h0);
      @(negedge clk);
      in_port = 32'h1;
      seen = 1'b0;
      for (int i = 0; i < SYNC_STAGES + 2 && !seen; i++) begin
         @(negedge clk);
         if (irq) seen = 1'b1;
      end
      check("irq_rise_within_bound", {31'b0, seen}, 32'h1);
      bus_read(2'd3, rd, rd_m);
      check("edgecap_bit0", rd, 32'h1);
      bus_write(2'd3, 32'h1);
      check("irq_after_clear", {31'b0, irq}, 32'h0);

      // Masked edge stays silent until the mask is opened.
      bus_write(2'd1, 32'h0);
      in_port = 32'h9;
      wait_cycles(5);
      bus_read(2'd3, rd, rd_m);
      check("edgecap_bit3", rd, 32'h8);
      check("irq_masked", {31'b0, irq}, 32'h0);
      bus_write(2'd1, 32'h8);
      check("irq_after_unmask", {31'b0, irq}, 32'h1);

      // Partial clear: write 0x1 to edgecapture holding 0x3.
      in_port = 32'h0;
      wait_cycles(5);
      bus_write(2'd3, 32'hFFFF_FFFF);
      in_port = 32'h3;
      wait_cycles(5);
      bus_read(2'd3, rd, rd_m);
      check("edgecap_three", rd, 32'h3);
      bus_write(2'd3, 32'h1);
      bus_read(2'd3, rd, rd_m);
`ifdef ADC_CAPTURE_BIT_CLEAR_EN
      check("partial_clear", rd, 32'h2);
`else
      check("partial_clear", rd, 32'h0);
`endif

      // Bit0 edge flag coincides with a clear of bits 1:0; bit0 must survive, bit1 must go.
      in_port = 32'h0;
      wait_cycles(5);
      bus_write(2'd3, 32'hFFFF_FFFF);
      in_port = 32'h2;
      wait_cycles(5);
      in_port = 32'h3;
      wait_cycles(SYNC_STAGES);
      bus.address    = 2'd3;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = 32'h3;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus_read(2'd3, rd, rd_m);
      check("set_beats_clear", rd, 32'h1);

      // Asynchronous reset mid-capture.
      in_port = 32'h0;
      wait_cycles(5);
      bus_write(2'd3, 32'hFFFF_FFFF);
      in_port = 32'hF;
      wait_cycles(5);
      bus_write(2'd1, 32'hF);
      check("pre_reset_irq", {31'b0, irq}, 32'h1);
      bus_read(2'd3, rd, rd_m);
      check("pre_reset_edgecap", rd, 32'hF);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_readdata", bus.readdata, 32'h0);
      check("async_reset_irq", {31'b0, irq}, 32'h0);
      in_port = 32'h0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(5);
      bus_read(2'd1, rd, rd_m);
      check("post_async_mask", rd, 32'h0);
      bus_read(2'd3, rd, rd_m);
      check("post_async_no_spurious", rd, 32'h0);

      // Randomized run against the reference model.
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               @(negedge clk);
               in_port = in_port ^ ($urandom() & $urandom() & $urandom());
            end
            1: bus_write(2'd1, $urandom());
            2: bus_write(2'd3, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom());
            3: begin
               bus_read(2'($urandom_range(0, 3)), rd, rd_m);
               check($sformatf("rand%0d_read", it), rd, rd_m);
            end
            default: @(negedge clk);
         endcase
         check($sformatf("rand%0d_irq", it), {31'b0, irq}, {31'b0, |(m_edgecap & m_mask)});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/soc_system_adc_capture.md
SOC_SYSTEM_ADC_CAPTURE -- requirements
Module: soc_system_adc_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 32; width of in_port and of the data, mask and capture registers (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0; 0 = rising, 1 = falling, 2 = any edge.
REQ-003 SHALL have parameter SYNC_STAGES, default 2; input synchronizer depth (2..4).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port address  input  2  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port in_port  input  WIDTH  fabric-side ADC status/data bits, asynchronous to clk.
REQ-011 SHALL have port readdata  output  32  read data, registered, read latency 1.
REQ-012 SHALL have port irq  output  1  level interrupt to HPS.

Function
REQ-013 SHALL pass each in_port bit through SYNC_STAGES flops, then one further flop (prev) for edge detection.
REQ-014 SHALL flag an edge per bit: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev.
REQ-015 SHALL implement this register map: 0 data (RO, synchronized in_port); 1 irqmask (RW); 2 reserved (reads 0, writes ignored); 3 edgecapture (RO plus clear).
REQ-016 SHALL accept a write when chipselect=1 and write_n=0, in that cycle only.
REQ-017 SHALL register readdata every cycle when chipselect=1 and write_n=1 from the addressed register, zero-extended above WIDTH; otherwise readdata holds its value.
REQ-018 SHALL set an edgecapture bit one cycle after its edge flag and hold it until cleared.
REQ-019 SHALL give set priority over clear when a bit's edge flag and its clear fall in the same cycle; the bit stays 1.
REQ-020 SHALL write irqmask from writedata[WIDTH-1:0] at address 1.
REQ-021 SHALL drive irq = OR over (edgecapture & irqmask), combinational from registers, with no synchronous delay.
REQ-022 SHALL pass the data register through latency: in_port change -> readdata at address 0 within SYNC_STAGES+1 cycles of the read request.
REQ-023 SHALL ignore writedata bits above WIDTH.

Reset
REQ-024 SHALL clear the synchronizer flops, prev, irqmask, edgecapture and readdata to 0 on reset_n low, asynchronously; irq is therefore 0.
REQ-025 SHALL not report spurious edges after reset release when in_port is held constant 0; a constant-1 input SHALL produce one rising edge after release (documented behaviour).

Configuration
REQ-026 SHALL, with ADC_CAPTURE_BIT_CLEAR_EN defined, make a write to address 3 clear only the edgecapture bits whose writedata bit is 1 (write-1-to-clear).
REQ-027 SHALL, without ADC_CAPTURE_BIT_CLEAR_EN, make any write to address 3 clear all edgecapture bits, regardless of writedata.

Structure
REQ-028 SHALL place the address constants (ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_RSVD=2, ADDR_EDGECAP=3) and the EDGE_TYPE encodings in package soc_system_adc_capture_pkg.
REQ-029 SHALL implement the synchronizer plus edge detector as sub-module soc_system_adc_capture_sync (parameters WIDTH, SYNC_STAGES, EDGE_TYPE; outputs sync and edge).

Verification
REQ-030 SHALL cover: reset, then read address 0 -> readdata=0, irq=0; in_port=0x0000_00A5 held 4 cycles, then read address 0 -> 0x0000_00A5.
REQ-031 SHALL cover: EDGE_TYPE=0, irqmask=0x1, in_port bit0 0->1 -> edgecapture=0x1, irq=1 within SYNC_STAGES+2 cycles; clear it -> irq=0 the next cycle.
REQ-032 SHALL cover: irqmask=0, edge on bit3 -> edgecapture=0x8, irq stays 0; then write irqmask=0x8 -> irq=1 the next cycle.
REQ-033 SHALL cover: with the macro defined, edgecapture=0x3, write 0x1 to address 3 -> edgecapture=0x2; without the macro, same write -> 0x0.
REQ-034 SHALL cover: a bit0 edge flag in the same cycle as a clear of bit0 -> edgecapture bit0 remains 1.
REQ-035 SHALL cover: reset_n pulsed low mid-capture (edgecapture=0xF, irqmask=0xF) -> all registers 0 and irq=0 immediately, without waiting for a clk edge.
